// File: rtl/freq_gate_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : freq_gate_ctrl_if
//  Description : Control/data bundle between the frequency-counter gate
//                sequencer and its host, counter and display path.
//  Revision    : 1.0 - initial release
// ============================================================================
interface freq_gate_ctrl_if;
    logic        START;
    logic        AUTO;
    logic        ABORT;
    logic [1:0]  RANGE;
    logic [23:0] CNT_Q;
    logic        CNT_ENA;
    logic        CNT_CLR;
    logic [23:0] RESULT;
    logic        VALID;
    logic        DONE;
    logic        BUSY;

    // Host / counter side: drives commands and the raw BCD count.
    modport master (
        output START, AUTO, ABORT, RANGE, CNT_Q,
        input  CNT_ENA, CNT_CLR, RESULT, VALID, DONE, BUSY
    );

    // Sequencer side.
    modport slave (
        input  START, AUTO, ABORT, RANGE, CNT_Q,
        output CNT_ENA, CNT_CLR, RESULT, VALID, DONE, BUSY
    );
endinterface
`default_nettype wire

// File: rtl/freq_gate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : freq_gate_ctrl
//  Description : Measurement sequencer for a 6-digit BCD frequency counter.
//                Issues the counter clear pulse, opens a gate window of
//                GATE_BASE x {1,10,100} cycles, waits for the counter to
//                settle, then latches the BCD count for the display path.
//                Single-shot or auto-repeat operation, with abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module freq_gate_ctrl #(
    parameter int unsigned GATE_BASE     = 1000,
    parameter int unsigned CLR_CYCLES    = 2,
    parameter int unsigned SETTLE_CYCLES = 3,
    parameter int unsigned HOLD_CYCLES   = 4
) (
    input  wire logic           CLK,
    input  wire logic           CLR,
    freq_gate_ctrl_if.slave     bus
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_clear  = 3'd1;
    localparam logic [2:0] c_st_count  = 3'd2;
    localparam logic [2:0] c_st_settle = 3'd3;
    localparam logic [2:0] c_st_latch  = 3'd4;
    localparam logic [2:0] c_st_hold   = 3'd5;

    // Timer reload values: the timer counts down to zero, so a state that
    // must last N cycles is entered with N-1.
    localparam logic [31:0] c_clr_load    = CLR_CYCLES - 1;
    localparam logic [31:0] c_settle_load = SETTLE_CYCLES - 1;
    localparam logic [31:0] c_hold_load   = HOLD_CYCLES - 1;

    // Gate lengths for the three decade ranges.
    localparam logic [31:0] c_gate_x1   = GATE_BASE;
    localparam logic [31:0] c_gate_x10  = GATE_BASE * 10;
    localparam logic [31:0] c_gate_x100 = GATE_BASE * 100;

    // ------------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------------
    logic [2:0]  r_state;
    logic [31:0] r_timer;
    logic [1:0]  r_range;
    logic [23:0] r_result;
    logic        r_valid;
    logic        r_done;

    logic [2:0]  w_state_nxt;
    logic [31:0] w_timer_nxt;
    logic [31:0] w_gate_len;
    logic        w_capture;
    logic        w_timer_zero;
    logic        w_abort;
    logic        w_latch_fire;

    assign w_timer_zero = (r_timer == 32'd0);

    // ABORT only acts while a measurement is in progress.
    assign w_abort = bus.ABORT && (r_state != c_st_idle);

    // The latch is suppressed when an abort lands on the LATCH cycle.
    assign w_latch_fire = (r_state == c_st_latch) && !bus.ABORT;

    // Gate length decoded from the captured range; code 3 falls back to x1.
    always_comb begin
        w_gate_len = c_gate_x1;
        case (r_range)
            2'd1:    w_gate_len = c_gate_x10;
            2'd2:    w_gate_len = c_gate_x100;
            default: w_gate_len = c_gate_x1;
        endcase
    end

    // Next-state and timer reload logic.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = w_timer_zero ? 32'd0 : (r_timer - 32'd1);
        w_capture   = 1'b0;

        case (r_state)
            c_st_idle: begin
                w_timer_nxt = 32'd0;
                // ABORT together with START keeps the block idle.
                if (!bus.ABORT && (bus.START || bus.AUTO)) begin
                    w_state_nxt = c_st_clear;
                    w_timer_nxt = c_clr_load;
                    w_capture   = 1'b1;
                end
            end
            c_st_clear: begin
                if (w_timer_zero) begin
                    w_state_nxt = c_st_count;
                    w_timer_nxt = w_gate_len - 32'd1;
                end
            end
            c_st_count: begin
                if (w_timer_zero) begin
                    w_state_nxt = c_st_settle;
                    w_timer_nxt = c_settle_load;
                end
            end
            c_st_settle: begin
                if (w_timer_zero) begin
                    w_state_nxt = c_st_latch;
                    w_timer_nxt = 32'd0;
                end
            end
            c_st_latch: begin
                w_state_nxt = c_st_hold;
                w_timer_nxt = c_hold_load;
            end
            c_st_hold: begin
                if (w_timer_zero) begin
                    if (bus.AUTO) begin
                        // Re-arm directly; the range is sampled afresh.
                        w_state_nxt = c_st_clear;
                        w_timer_nxt = c_clr_load;
                        w_capture   = 1'b1;
                    end else begin
                        w_state_nxt = c_st_idle;
                        w_timer_nxt = 32'd0;
                    end
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_timer_nxt = 32'd0;
            end
        endcase

        // Abort overrides every in-progress transition.
        if (w_abort) begin
            w_state_nxt = c_st_idle;
            w_timer_nxt = 32'd0;
            w_capture   = 1'b0;
        end
    end

    // State and timer registers.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state <= c_st_idle;
            r_timer <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    // Range is captured only when a measurement is armed.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_range <= 2'd0;
        end else if (w_capture) begin
            r_range <= bus.RANGE;
        end
    end

    // Result latch, valid flag and one-cycle completion pulse.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_result <= 24'd0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_latch_fire;
            if (w_latch_fire) begin
                r_result <= bus.CNT_Q;
                r_valid  <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: decoded from registered state, so enable and clear can never
    // overlap and no input reaches an output combinationally.
    // ------------------------------------------------------------------------
    assign bus.CNT_CLR = (r_state == c_st_clear);
    assign bus.CNT_ENA = (r_state == c_st_count);
    assign bus.BUSY    = (r_state != c_st_idle);
    assign bus.RESULT  = r_result;
    assign bus.VALID   = r_valid;
    assign bus.DONE    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_freq_gate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_freq_gate_ctrl
//  Description : Directed self-checking bench for freq_gate_ctrl with a
//                behavioural BCD counter driven by CNT_CLR / CNT_ENA.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_freq_gate_ctrl;

    localparam int unsigned GATE_BASE     = 10;
    localparam int unsigned CLR_CYCLES    = 2;
    localparam int unsigned SETTLE_CYCLES = 3;
    localparam int unsigned HOLD_CYCLES   = 4;

    logic clk;
    logic clr;
    int   vectors;
    int   miscompares;

    logic [23:0] cnt_model;

    freq_gate_ctrl_if bus ();

    freq_gate_ctrl #(
        .GATE_BASE     (GATE_BASE),
        .CLR_CYCLES    (CLR_CYCLES),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .HOLD_CYCLES   (HOLD_CYCLES)
    ) u_dut (
        .CLK (clk),
        .CLR (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Six-digit BCD increment with decimal carry.
    function automatic logic [23:0] bcd_inc(input logic [23:0] v);
        logic [23:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int d = 0; d < 6; d++) begin
            if (carry) begin
                if (r[d*4 +: 4] == 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                end else begin
                    r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Model counter: cleared by CNT_CLR, counts reference edges under CNT_ENA.
    always_ff @(posedge clk) begin
        if (clr || bus.CNT_CLR)
            cnt_model <= 24'd0;
        else if (bus.CNT_ENA)
            cnt_model <= bcd_inc(cnt_model);
    end
    assign bus.CNT_Q = cnt_model;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One single-shot at RANGE=0. Cycle 0 is the START cycle; outputs are
    // checked mid-cycle. Optional pokes pulse START in CLEAR, COUNT and HOLD.
    task automatic single_shot(input int run, input bit poke, input logic [23:0] prev);
        logic [3:0]  exp_ctl;
        logic [23:0] exp_res;
        for (int c = 0; c <= 22; c++) begin
            @(negedge clk);
            bus.RANGE = 2'd0;
            bus.START = (c == 0) || (poke && (c == 2 || c == 5 || c == 18));
            exp_ctl = {(c >= 1 && c <= 2), (c >= 3 && c <= 12), (c == 17), (c >= 1 && c <= 20)};
            exp_res = (c >= 17) ? 24'h000010 : prev;
            chk($sformatf("ss%0d_ctl_c%0d", run, c),
                {28'd0, bus.CNT_CLR, bus.CNT_ENA, bus.DONE, bus.BUSY}, {28'd0, exp_ctl});
            chk($sformatf("ss%0d_res_c%0d", run, c), {8'd0, bus.RESULT}, {8'd0, exp_res});
        end
        chk($sformatf("ss%0d_valid", run), {31'd0, bus.VALID}, 32'd1);
    endtask

    // Measurement with a range, optional mid-run range change; returns the
    // number of gate cycles seen and the cycle DONE appeared (-1 if never).
    task automatic run_meas(input logic [1:0] rng, input int change_at, input logic [1:0] rng2,
                            output int ena_cnt, output int cyc_done);
        ena_cnt  = 0;
        cyc_done = -1;
        @(negedge clk);
        bus.RANGE = rng;
        bus.START = 1'b1;
        for (int c = 1; c < 3000; c++) begin
            @(negedge clk);
            bus.START = 1'b0;
            if (c == change_at) bus.RANGE = rng2;
            if (bus.CNT_ENA) ena_cnt++;
            if (bus.DONE) begin
                cyc_done = c;
                break;
            end
        end
        for (int c = 0; c < 10 && bus.BUSY; c++) @(negedge clk);
    endtask

    // Global time bound.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, vectors=%0d", vectors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int ena_cnt;
        int cyc_done;
        logic done_any;
        int done_cyc[$];

        vectors     = 0;
        miscompares = 0;
        clr         = 1'b1;
        bus.START   = 1'b0;
        bus.AUTO    = 1'b0;
        bus.ABORT   = 1'b0;
        bus.RANGE   = 2'd0;

        // ---------------- Reset state ----------------
        repeat (3) @(negedge clk);
        chk("rst_ctl", {28'd0, bus.CNT_CLR, bus.CNT_ENA, bus.DONE, bus.BUSY}, 32'd0);
        chk("rst_result", {8'd0, bus.RESULT}, 32'd0);
        chk("rst_valid", {31'd0, bus.VALID}, 32'd0);
        clr = 1'b0;

        // ---------------- Single shot, plain and with ignored STARTs -------
        single_shot(0, 1'b0, 24'h000000);
        single_shot(1, 1'b1, 24'h000010);

        // ---------------- Range x100, changed to x10 mid-gate ---------------
        run_meas(2'd2, 100, 2'd1, ena_cnt, cyc_done);
        chk("rng2_ena_cycles", ena_cnt, 32'd1000);
        chk("rng2_done_cycle", cyc_done, 32'd1007);
        chk("rng2_result", {8'd0, bus.RESULT}, 32'h001000);
        chk("rng2_busy", {31'd0, bus.BUSY}, 32'd0);

        // ---------------- Range code 3 behaves as x1 -----------------------
        run_meas(2'd3, -1, 2'd3, ena_cnt, cyc_done);
        chk("rng3_ena_cycles", ena_cnt, 32'd10);
        chk("rng3_done_cycle", cyc_done, 32'd17);
        chk("rng3_result", {8'd0, bus.RESULT}, 32'h000010);

        // ---------------- Abort during COUNT -------------------------------
        done_any = 1'b0;
        for (int c = 0; c <= 25; c++) begin
            @(negedge clk);
            bus.RANGE = 2'd0;
            bus.START = (c == 0);
            bus.ABORT = (c == 5);
            if (c == 5) chk("abc_ena_before", {31'd0, bus.CNT_ENA}, 32'd1);
            if (c == 6) begin
                chk("abc_ena", {31'd0, bus.CNT_ENA}, 32'd0);
                chk("abc_busy", {31'd0, bus.BUSY}, 32'd0);
                chk("abc_result", {8'd0, bus.RESULT}, 32'h000010);
                chk("abc_valid", {31'd0, bus.VALID}, 32'd1);
            end
            if (c >= 6) done_any = done_any | bus.DONE;
        end
        chk("abc_no_done", {31'd0, done_any}, 32'd0);

        // ---------------- Abort on the LATCH cycle (x10 gate) --------------
        // CLEAR 1-2, COUNT 3-102, SETTLE 103-105, LATCH 106.
        done_any = 1'b0;
        for (int c = 0; c <= 120; c++) begin
            @(negedge clk);
            bus.RANGE = 2'd1;
            bus.START = (c == 0);
            bus.ABORT = (c == 106);
            if (c == 106) chk("abl_busy_before", {31'd0, bus.BUSY}, 32'd1);
            if (c == 107) begin
                chk("abl_busy", {31'd0, bus.BUSY}, 32'd0);
                chk("abl_result", {8'd0, bus.RESULT}, 32'h000010);
            end
            if (c >= 100) done_any = done_any | bus.DONE;
        end
        chk("abl_no_done", {31'd0, done_any}, 32'd0);
        bus.RANGE = 2'd0;

        // ---------------- Auto mode -----------------------------------------
        // Period = CLEAR 2 + COUNT 10 + SETTLE 3 + LATCH 1 + HOLD 4 = 20 cycles.
        // AUTO drops at cycle 45 (third COUNT, 43-52); it still completes.
        for (int c = 0; c <= 63; c++) begin
            @(negedge clk);
            if (c == 0)  bus.AUTO = 1'b1;
            if (c == 45) bus.AUTO = 1'b0;
            if (bus.DONE) done_cyc.push_back(c);
            if (c == 21) chk("auto_clr_rearm1", {31'd0, bus.CNT_CLR}, 32'd1);
            if (c == 41) chk("auto_clr_rearm2", {31'd0, bus.CNT_CLR}, 32'd1);
            if (c == 37) chk("auto_result2", {8'd0, bus.RESULT}, 32'h000010);
            if (c == 60) chk("auto_busy_hold", {31'd0, bus.BUSY}, 32'd1);
            if (c == 61) chk("auto_idle", {31'd0, bus.BUSY}, 32'd0);
            if (c == 63) chk("auto_stays_idle", {31'd0, bus.BUSY}, 32'd0);
        end
        chk("auto_done_count", done_cyc.size(), 32'd3);
        if (done_cyc.size() == 3) begin
            chk("auto_done0", done_cyc[0], 32'd17);
            chk("auto_done1", done_cyc[1], 32'd37);
            chk("auto_done2", done_cyc[2], 32'd57);
        end

        // ---------------- ABORT + START in the same IDLE cycle -------------
        @(negedge clk);
        bus.START = 1'b1;
        bus.ABORT = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
        bus.ABORT = 1'b0;
        chk("abst_busy1", {31'd0, bus.BUSY}, 32'd0);
        chk("abst_clr1", {31'd0, bus.CNT_CLR}, 32'd0);
        @(negedge clk);
        chk("abst_busy2", {31'd0, bus.BUSY}, 32'd0);

        // ---------------- Reset during SETTLE (13-15) -----------------------
        for (int c = 0; c <= 18; c++) begin
            @(negedge clk);
            bus.START = (c == 0) || (c == 14) || (c == 16);
            clr       = (c >= 14 && c <= 16);
            if (c == 14) chk("rsm_busy_before", {31'd0, bus.BUSY}, 32'd1);
            if (c == 15) begin
                chk("rsm_ctl", {28'd0, bus.CNT_CLR, bus.CNT_ENA, bus.DONE, bus.BUSY}, 32'd0);
                chk("rsm_result", {8'd0, bus.RESULT}, 32'd0);
                chk("rsm_valid", {31'd0, bus.VALID}, 32'd0);
            end
            if (c == 17) chk("rsm_busy17", {31'd0, bus.BUSY}, 32'd0);
            if (c == 18) chk("rsm_busy18", {31'd0, bus.BUSY}, 32'd0);
        end
        bus.START = 1'b0;
        clr       = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
